// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path (and reusable by UART_Tx):
//   - rx_state_e  : receiver state machine encoding
//   - OVERSAMPLE  : sample ticks per bit period (always 16)
//   - MID_SAMPLE  : tick index that lands in the middle of the start bit
//   - calc_div()  : clock cycles per oversample tick, rounded to nearest
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_e;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;

  // Rounded-to-nearest divide so that odd clock/baud ratios do not all
  // truncate towards a fast tick.
  function automatic int calc_div(input int clk_freq, input int baud);
    int denom;
    denom = baud * OVERSAMPLE;
    return (clk_freq + denom / 2) / denom;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// ---------------------------------------------------------------------------
// uart_rx_if
// Consumer-side bundle of the UART receiver.
//   rx_data   : last good received byte
//   rx_valid  : rx_data holds an unacknowledged byte
//   rx_ack    : one-clk acknowledge pulse from the consumer
//   frame_err : sticky, stop bit sampled low
//   overrun   : sticky, a byte was dropped because rx_valid was still set
//   rx_busy   : a frame is being received
// Modports: master = the receiver, slave = the consumer.
// ---------------------------------------------------------------------------
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic       frame_err;
  logic       overrun;
  logic       rx_busy;

  modport master (
    output rx_data,
    output rx_valid,
    output frame_err,
    output overrun,
    output rx_busy,
    input  rx_ack
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  overrun,
    input  rx_busy,
    output rx_ack
  );
endinterface

// File: rtl/uart_baud_tick.sv
// ---------------------------------------------------------------------------
// uart_baud_tick
// Free-running divider that emits a one-clk tick every DIV clocks.
// Ports:
//   clk    : system clock
//   rst    : synchronous active-low reset, clears the counter
//   clr_i  : synchronous clear, realigns the tick phase (e.g. to a start edge)
//   tick_o : high for one clk when the counter sits at DIV-1
// ---------------------------------------------------------------------------
module uart_baud_tick #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: wrap at DIV-1, or restart from zero when the owner asks for
  // a fresh phase.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver with 16x oversampling, mid-bit sampling, start-bit
// glitch rejection, framing and overrun detection, and a one-byte holding
// register handed to the consumer through a valid/ack handshake.
// Ports:
//   clk    : system clock, all logic on the rising edge
//   rst    : synchronous active-low reset
//   rxd_in : asynchronous serial input, idles high
//   rx_if  : uart_rx_if.master (rx_data, rx_valid, rx_ack, frame_err,
//            overrun, rx_busy)
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rxd_in,
  uart_rx_if.master    rx_if
);

  import uart_pkg::*;

  localparam int DIV    = calc_div(CLK_FREQ, BAUD);
  localparam int SCNT_W = $clog2(OVERSAMPLE);
  localparam logic [SCNT_W-1:0] LAST_CNT = SCNT_W'(OVERSAMPLE - 1);
  localparam logic [SCNT_W-1:0] MID_CNT  = SCNT_W'(MID_SAMPLE);

  logic              sync1_q;
  logic              line_q;
  rx_state_e         state_q,  state_d;
  logic [SCNT_W-1:0] scnt_q,   scnt_d;
  logic [2:0]        bidx_q,   bidx_d;
  logic [7:0]        shift_q,  shift_d;
  logic [7:0]        data_q,   data_d;
  logic              valid_q,  valid_d;
  logic              ferr_q,   ferr_d;
  logic              ovr_q,    ovr_d;
  logic              busy_q,   busy_d;
  logic              tick;
  logic              tick_clr;
  logic              good_stop;

  uart_baud_tick #(
    .DIV (DIV)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (tick_clr),
    .tick_o (tick)
  );

  // Next-state logic for the frame FSM and the holding register.
  // In WAIT_IDLE scnt is reused as the run length of consecutive high
  // ticks; elsewhere it counts ticks within the current bit.
  always_comb begin
    state_d   = state_q;
    scnt_d    = scnt_q;
    bidx_d    = bidx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = valid_q;
    ferr_d    = ferr_q;
    ovr_d     = ovr_q;
    tick_clr  = 1'b0;
    good_stop = 1'b0;

    case (state_q)
      WAIT_IDLE: begin
        if (tick) begin
          if (!line_q) begin
            scnt_d = '0;
          end else if (scnt_q == LAST_CNT) begin
            scnt_d  = '0;
            state_d = IDLE;
          end else begin
            scnt_d = scnt_q + 1'b1;
          end
        end
      end

      IDLE: begin
        if (!line_q) begin
          state_d  = START;
          scnt_d   = '0;
          tick_clr = 1'b1;
        end
      end

      START: begin
        if (tick) begin
          if (scnt_q == MID_CNT) begin
            scnt_d = '0;
            if (!line_q) begin
              state_d = DATA;
              bidx_d  = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            scnt_d = scnt_q + 1'b1;
          end
        end
      end

      DATA: begin
        if (tick) begin
          if (scnt_q == LAST_CNT) begin
            scnt_d  = '0;
            shift_d = {line_q, shift_q[7:1]};
            bidx_d  = bidx_q + 1'b1;
            if (bidx_q == 3'd7) begin
              state_d = STOP;
            end
          end else begin
            scnt_d = scnt_q + 1'b1;
          end
        end
      end

      STOP: begin
        if (tick) begin
          if (scnt_q == LAST_CNT) begin
            scnt_d = '0;
            if (line_q) begin
              good_stop = 1'b1;
              state_d   = IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = WAIT_IDLE;
            end
          end else begin
            scnt_d = scnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = WAIT_IDLE;
        scnt_d  = '0;
      end
    endcase

    // A same-clk ack frees the holding register for the new byte, so only
    // a completion with no room and no ack counts as an overrun.
    if (good_stop) begin
      if (!valid_q || rx_if.rx_ack) begin
        data_d  = shift_q;
        valid_d = 1'b1;
        ferr_d  = 1'b0;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (rx_if.rx_ack && valid_q) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  // Busy is registered from the next state so it changes on the same edge
  // as the state register.
  always_comb begin
    busy_d = (state_d != IDLE) && (state_d != WAIT_IDLE);
  end

  // State and output registers plus the two-flop input synchronizer, which
  // resets to the idle line level.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      line_q  <= 1'b1;
      state_q <= WAIT_IDLE;
      scnt_q  <= '0;
      bidx_q  <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync1_q <= rxd_in;
      line_q  <= sync1_q;
      state_q <= state_d;
      scnt_q  <= scnt_d;
      bidx_q  <= bidx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
    end
  end

  assign rx_if.rx_data   = data_q;
  assign rx_if.rx_valid  = valid_q;
  assign rx_if.frame_err = ferr_q;
  assign rx_if.overrun   = ovr_q;
  assign rx_if.rx_busy   = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
// Self-checking bench for uart_rx at CLK_FREQ=1.6 MHz, BAUD=10 kbit/s
// (10 clk per tick, 160 clk per bit). Frames are driven bit by bit and the
// consumer-side outputs are compared against hand-computed values.
// ---------------------------------------------------------------------------
module tb_uart_rx;

  localparam int BIT_CLK = 160;

  logic clk = 1'b0;
  logic rst;
  logic rxd_in;

  uart_rx_if rxIf ();

  uart_rx #(
    .CLK_FREQ (1_600_000),
    .BAUD     (10_000)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .rxd_in (rxd_in),
    .rx_if  (rxIf)
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int failCount  = 0;

  typedef struct {
    logic [7:0] txByte;
    logic       stopBit;
    logic       ackAfter;
    logic [7:0] expData;
    logic       expValid;
    logic       expFrameErr;
    logic       expOverrun;
  } vector_t;

  vector_t vectors[7];

  // Advance n rising edges and settle 1 time unit past the last one, so all
  // driving and sampling happens away from the active edge.
  task automatic waitClk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] actual,
                             input logic [7:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", name, actual, expected);
    end
  endtask

  task automatic checkFlag(input string name, input logic actual,
                           input logic expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
    end
  endtask

  // Drive one 8N1 frame, LSB first, then return the line to idle.
  task automatic applyStimulus(input logic [7:0] txByte, input logic stopBit);
    rxd_in = 1'b0;
    waitClk(BIT_CLK);
    for (int i = 0; i < 8; i++) begin
      rxd_in = txByte[i];
      waitClk(BIT_CLK);
    end
    rxd_in = stopBit;
    waitClk(BIT_CLK);
    rxd_in = 1'b1;
  endtask

  task automatic pulseAck();
    rxIf.rx_ack = 1'b1;
    waitClk(1);
    rxIf.rx_ack = 1'b0;
  endtask

  // Main sequence: reset, latency frame, vector table, then the multi-cycle
  // corner cases (glitch, ack on completion, reset mid-frame).
  initial begin
    logic [7:0] abortByte;
    int         waited;

    rst         = 1'b0;
    rxd_in      = 1'b1;
    rxIf.rx_ack = 1'b0;
    waitClk(3);

    checkOutput("reset rx_data", rxIf.rx_data, 8'h00);
    checkFlag("reset rx_valid", rxIf.rx_valid, 1'b0);
    checkFlag("reset frame_err", rxIf.frame_err, 1'b0);
    checkFlag("reset overrun", rxIf.overrun, 1'b0);
    checkFlag("reset rx_busy", rxIf.rx_busy, 1'b0);

    rst = 1'b1;
    waitClk(250);

    $display("[TB] latency frame 0x41");
    fork
      applyStimulus(8'h41, 1'b1);
      begin
        waitClk(1522);
        checkFlag("0x41 valid before stop sample", rxIf.rx_valid, 1'b0);
        waitClk(2);
        checkFlag("0x41 valid after stop sample", rxIf.rx_valid, 1'b1);
      end
    join
    checkOutput("0x41 rx_data", rxIf.rx_data, 8'h41);
    checkFlag("0x41 frame_err", rxIf.frame_err, 1'b0);
    checkFlag("0x41 overrun", rxIf.overrun, 1'b0);
    checkFlag("0x41 rx_busy", rxIf.rx_busy, 1'b0);
    waitClk(500);
    checkFlag("0x41 valid held", rxIf.rx_valid, 1'b1);
    checkOutput("0x41 data held", rxIf.rx_data, 8'h41);
    pulseAck();
    checkFlag("0x41 valid after ack", rxIf.rx_valid, 1'b0);
    checkFlag("0x41 overrun after ack", rxIf.overrun, 1'b0);
    waitClk(240);

    vectors[0] = '{8'h55, 1'b0, 1'b0, 8'h41, 1'b0, 1'b1, 1'b0};
    vectors[1] = '{8'h0D, 1'b1, 1'b1, 8'h0D, 1'b1, 1'b0, 1'b0};
    vectors[2] = '{8'h31, 1'b1, 1'b0, 8'h31, 1'b1, 1'b0, 1'b0};
    vectors[3] = '{8'h32, 1'b1, 1'b1, 8'h31, 1'b1, 1'b0, 1'b1};
    vectors[4] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
    vectors[5] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
    vectors[6] = '{8'h80, 1'b1, 1'b1, 8'h80, 1'b1, 1'b0, 1'b0};

    $display("[TB] vector table");
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vectors[i].txByte, vectors[i].stopBit);
      checkOutput($sformatf("vec%0d rx_data", i), rxIf.rx_data, vectors[i].expData);
      checkFlag($sformatf("vec%0d rx_valid", i), rxIf.rx_valid, vectors[i].expValid);
      checkFlag($sformatf("vec%0d frame_err", i), rxIf.frame_err, vectors[i].expFrameErr);
      checkFlag($sformatf("vec%0d overrun", i), rxIf.overrun, vectors[i].expOverrun);
      if (vectors[i].ackAfter) begin
        pulseAck();
        checkFlag($sformatf("vec%0d valid after ack", i), rxIf.rx_valid, 1'b0);
        checkFlag($sformatf("vec%0d overrun after ack", i), rxIf.overrun, 1'b0);
        checkOutput($sformatf("vec%0d data after ack", i), rxIf.rx_data, vectors[i].expData);
      end
      waitClk(240);
    end

    $display("[TB] start-bit glitch");
    rxd_in = 1'b0;
    waitClk(10);
    checkFlag("glitch busy rises", rxIf.rx_busy, 1'b1);
    waitClk(40);
    rxd_in = 1'b1;
    waited = 0;
    while (rxIf.rx_busy && waited < 80) begin
      waitClk(1);
      waited++;
    end
    checkFlag("glitch busy released within 80 clk", rxIf.rx_busy, 1'b0);
    waitClk(240);
    checkFlag("glitch rx_valid", rxIf.rx_valid, 1'b0);
    checkFlag("glitch frame_err", rxIf.frame_err, 1'b0);

    $display("[TB] ack on completion clk");
    applyStimulus(8'h31, 1'b1);
    checkOutput("first 0x31 rx_data", rxIf.rx_data, 8'h31);
    checkFlag("first 0x31 rx_valid", rxIf.rx_valid, 1'b1);
    waitClk(240);
    fork
      applyStimulus(8'h32, 1'b1);
      begin
        waitClk(1522);
        rxIf.rx_ack = 1'b1;
        waitClk(1);
        rxIf.rx_ack = 1'b0;
      end
    join
    checkOutput("ack-same-clk rx_data", rxIf.rx_data, 8'h32);
    checkFlag("ack-same-clk rx_valid", rxIf.rx_valid, 1'b1);
    checkFlag("ack-same-clk overrun", rxIf.overrun, 1'b0);
    checkFlag("ack-same-clk frame_err", rxIf.frame_err, 1'b0);
    waitClk(240);

    // The sender abandons 0xA5 when the reset hits and the line goes idle.
    $display("[TB] reset during bit 3 of 0xA5");
    abortByte = 8'hA5;
    rxd_in = 1'b0;
    waitClk(BIT_CLK);
    for (int i = 0; i < 3; i++) begin
      rxd_in = abortByte[i];
      waitClk(BIT_CLK);
    end
    rxd_in = abortByte[3];
    waitClk(BIT_CLK / 2);
    rst = 1'b0;
    waitClk(1);
    rst    = 1'b1;
    rxd_in = 1'b1;
    checkOutput("midframe reset rx_data", rxIf.rx_data, 8'h00);
    checkFlag("midframe reset rx_valid", rxIf.rx_valid, 1'b0);
    checkFlag("midframe reset frame_err", rxIf.frame_err, 1'b0);
    checkFlag("midframe reset overrun", rxIf.overrun, 1'b0);
    checkFlag("midframe reset rx_busy", rxIf.rx_busy, 1'b0);
    waitClk(2 * BIT_CLK);
    checkFlag("no byte from aborted frame", rxIf.rx_valid, 1'b0);
    applyStimulus(8'h7E, 1'b1);
    checkOutput("0x7E rx_data", rxIf.rx_data, 8'h7E);
    checkFlag("0x7E rx_valid", rxIf.rx_valid, 1'b1);
    checkFlag("0x7E frame_err", rxIf.frame_err, 1'b0);
    checkFlag("0x7E overrun", rxIf.overrun, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
